// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl: APB interrupt controller for peripheral wrappers.
//
// Collects NUM_SRC interrupt sources into one registered IRQ line.
// Each source has its own polarity and its own mode. An edge-mode source
// latches a sticky RIS bit. A level-mode source follows the live input,
// ORed with a software-set bit. IRQ assertion can be coalesced by an
// event count (COAL) and by a timeout (TMO).
//
// Register map (PADDR[15:0]):
//   0x0F00 RIS  RO   0x0F04 IM   RW   0x0F08 MIS  RO   0x0F0C ICR  WO (W1C)
//   0x0F10 ISET WO   0x0F14 MODE RW   0x0F18 COAL RW   0x0F1C TMO  RW
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL/PENABLE/PWRITE  APB control
//   PADDR, PWDATA        APB address (only [15:0] decoded) and write data
//   PRDATA               combinational read data (0xDEADBEEF when unmapped)
//   PREADY               tied to 1
//   PSLVERR              access to an unmapped address, or a write to RIS/MIS
//   irq_src              raw interrupt sources
//   IRQ                  registered interrupt request
module apb_irq_ctrl #(
  parameter int unsigned          NUM_SRC      = 16,
  parameter logic [NUM_SRC-1:0]   ACTIVE_LOW   = '0,
  parameter logic [NUM_SRC-1:0]   EDGE_DEFAULT = '0,
  parameter int unsigned          SYNC_STAGES  = 2,
  parameter int unsigned          COAL_W       = 8,
  parameter int unsigned          TMO_W        = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               IRQ
);

  localparam logic [15:0] ADDR_RIS  = 16'h0F00;
  localparam logic [15:0] ADDR_IM   = 16'h0F04;
  localparam logic [15:0] ADDR_MIS  = 16'h0F08;
  localparam logic [15:0] ADDR_ICR  = 16'h0F0C;
  localparam logic [15:0] ADDR_ISET = 16'h0F10;
  localparam logic [15:0] ADDR_MODE = 16'h0F14;
  localparam logic [15:0] ADDR_COAL = 16'h0F18;
  localparam logic [15:0] ADDR_TMO  = 16'h0F1C;

  logic [15:0] addr;
  logic        unused_apb;
  assign addr       = PADDR[15:0];
  assign unused_apb = ^{PADDR[31:16], PWDATA};

  // Input synchroniser; flops reset to ACTIVE_LOW so every source reads
  // inactive out of reset and no false edge is seen at reset release.
  logic [NUM_SRC-1:0] src_sync;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_sync = irq_src;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= ACTIVE_LOW;
        end else begin
          sync_q[0] <= irq_src;
          for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
      end
      assign src_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [NUM_SRC-1:0] src_q, src_d_q, src_edge;
  assign src_q    = src_sync ^ ACTIVE_LOW;
  assign src_edge = src_q & ~src_d_q;

  logic [NUM_SRC-1:0] im_q, im_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] ris_edge_q, ris_edge_d;
  logic [NUM_SRC-1:0] swset_q, swset_d;
  logic [COAL_W-1:0]  coal_q, coal_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [COAL_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmr_q, tmr_d;
  logic               irq_q, irq_d;

  logic               wr_en, icr_wr, iset_wr;
  logic [NUM_SRC-1:0] icr_bits, iset_bits, mode_chg;
  logic [NUM_SRC-1:0] ris, mis;
  logic               new_evt, fire, cnt_clr;

  // Edge-mode bits show the sticky latch, level-mode bits the live level.
  assign ris = (mode_q & ris_edge_q) | (~mode_q & (src_q | swset_q));
  assign mis = ris & im_q;

  always_comb begin
    wr_en     = PSEL & PENABLE & PWRITE;
    icr_wr    = wr_en && (addr == ADDR_ICR);
    iset_wr   = wr_en && (addr == ADDR_ISET);
    icr_bits  = icr_wr  ? PWDATA[NUM_SRC-1:0] : '0;
    iset_bits = iset_wr ? PWDATA[NUM_SRC-1:0] : '0;

    im_d   = (wr_en && (addr == ADDR_IM))   ? PWDATA[NUM_SRC-1:0] : im_q;
    mode_d = (wr_en && (addr == ADDR_MODE)) ? PWDATA[NUM_SRC-1:0] : mode_q;
    coal_d = (wr_en && (addr == ADDR_COAL)) ? PWDATA[COAL_W-1:0]  : coal_q;
    tmo_d  = (wr_en && (addr == ADDR_TMO))  ? PWDATA[TMO_W-1:0]   : tmo_q;

    // A bit whose mode flips loses its latched/software state.
    mode_chg = mode_q ^ mode_d;

    // Set (edge or ISET) is ORed in after the clear, so set wins.
    ris_edge_d = ((ris_edge_q & ~icr_bits) | src_edge | iset_bits) & mode_q & ~mode_chg;
    swset_d    = ((swset_q & ~icr_bits) | iset_bits) & ~mode_q & ~mode_chg;

    new_evt = (|(src_edge & im_q & mode_q)) | (|(iset_bits & im_q));
    fire    = (coal_q == '0) | (cnt_q >= coal_q) | ((tmo_q != '0) & (tmr_q >= tmo_q));

    // The event that makes MIS non-zero arrives while MIS is still zero;
    // it must not be cleared away, or the first event would never count.
    cnt_clr = icr_wr | (~(|mis) & ~new_evt);

    if (cnt_clr)                       cnt_d = '0;
    else if (new_evt && cnt_q != '1)   cnt_d = cnt_q + COAL_W'(1);
    else                               cnt_d = cnt_q;

    if (cnt_clr)                                  tmr_d = '0;
    else if ((|mis) && !fire && tmr_q != '1)      tmr_d = tmr_q + TMO_W'(1);
    else                                          tmr_d = tmr_q;

    irq_d = (|mis) & fire;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      src_d_q    <= '0;
      im_q       <= '0;
      mode_q     <= EDGE_DEFAULT;
      ris_edge_q <= '0;
      swset_q    <= '0;
      coal_q     <= '0;
      tmo_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      src_d_q    <= src_q;
      im_q       <= im_d;
      mode_q     <= mode_d;
      ris_edge_q <= ris_edge_d;
      swset_q    <= swset_d;
      coal_q     <= coal_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      irq_q      <= irq_d;
    end
  end

  logic [31:0] rdata;
  logic        unmapped;

  always_comb begin
    rdata    = '0;
    unmapped = 1'b0;
    case (addr)
      ADDR_RIS:  rdata[NUM_SRC-1:0] = ris;
      ADDR_IM:   rdata[NUM_SRC-1:0] = im_q;
      ADDR_MIS:  rdata[NUM_SRC-1:0] = mis;
      ADDR_ICR:  rdata = '0;
      ADDR_ISET: rdata = '0;
      ADDR_MODE: rdata[NUM_SRC-1:0] = mode_q;
      ADDR_COAL: rdata[COAL_W-1:0]  = coal_q;
      ADDR_TMO:  rdata[TMO_W-1:0]   = tmo_q;
      default: begin
        rdata    = 32'hDEAD_BEEF;
        unmapped = 1'b1;
      end
    endcase
  end

  assign PRDATA  = rdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE &
                   (unmapped | (PWRITE & ((addr == ADDR_RIS) | (addr == ADDR_MIS))));
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
module tb_apb_irq_ctrl;
  localparam int NS = 16;
  localparam logic [31:0] A_RIS  = 32'h0F00;
  localparam logic [31:0] A_IM   = 32'h0F04;
  localparam logic [31:0] A_MIS  = 32'h0F08;
  localparam logic [31:0] A_ICR  = 32'h0F0C;
  localparam logic [31:0] A_ISET = 32'h0F10;
  localparam logic [31:0] A_MODE = 32'h0F14;
  localparam logic [31:0] A_COAL = 32'h0F18;
  localparam logic [31:0] A_TMO  = 32'h0F1C;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0]   PADDR = '0, PWDATA = '0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR, IRQ;
  logic [NS-1:0] irq_src = 16'h0008;   // source 3 is active-low, idle high

  apb_irq_ctrl #(
    .NUM_SRC(16), .ACTIVE_LOW(16'h0008), .EDGE_DEFAULT(16'h00F0),
    .SYNC_STAGES(2), .COAL_W(8), .TMO_W(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .irq_src(irq_src), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    bit          err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit w, logic [31:0] a, logic [31:0] d,
                              logic [31:0] x, bit er, string nm);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.exp = x; v.err = er; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA; err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  // Read data is combinational from PADDR, so registers can be watched
  // cycle by cycle without spending APB cycles.
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    PADDR = a;
    #1 d = PRDATA;
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    @(negedge PCLK); irq_src = irq_src ^ m;
    @(negedge PCLK); irq_src = irq_src ^ m;
    tick(4);
  endtask

  task automatic tmo_rise(input string nm);
    logic [31:0] d;
    int rise;
    @(negedge PCLK); irq_src[0] = 1'b1;
    @(posedge PCLK); #1;
    @(negedge PCLK); irq_src[0] = 1'b0;
    tick(1); peek(A_RIS, d); chk({nm, "_ris_p2"}, d, 32'h0);
    tick(1); peek(A_RIS, d); chk({nm, "_ris_p3"}, d, 32'h1);
    rise = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (IRQ === 1'b1) begin
        rise = k;
        break;
      end
    end
    chk({nm, "_cycles"}, 32'(rise), 32'd21);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    add(0, A_RIS,  0, 32'h0,        0, "ris_rst");
    add(0, A_IM,   0, 32'h0,        0, "im_rst");
    add(0, A_MIS,  0, 32'h0,        0, "mis_rst");
    add(0, A_ICR,  0, 32'h0,        0, "icr_rd0");
    add(0, A_ISET, 0, 32'h0,        0, "iset_rd0");
    add(0, A_MODE, 0, 32'h00F0,     0, "mode_rst");
    add(0, A_COAL, 0, 32'h0,        0, "coal_rst");
    add(0, A_TMO,  0, 32'h0,        0, "tmo_rst");
    add(0, 32'h0F20, 0, 32'hDEADBEEF, 1, "unmapped_rd");
    add(1, A_IM,   32'hFFFF1234, 0, 0, "im_wr");
    add(0, A_IM,   0, 32'h1234,     0, "im_rd");
    add(0, 32'hABCD0F04, 0, 32'h1234, 0, "im_hi_alias");
    add(1, A_ISET, 32'h0200, 0,     0, "iset_wr");
    add(0, A_RIS,  0, 32'h0200,     0, "ris_swset");
    add(0, A_MIS,  0, 32'h0200,     0, "mis_swset");
    add(1, A_ICR,  32'h0200, 0,     0, "icr_wr");
    add(0, A_RIS,  0, 32'h0,        0, "ris_icr");
    add(1, A_RIS,  32'h1, 0,        1, "ris_ro");
    add(1, A_MIS,  32'h1, 0,        1, "mis_ro");
    add(1, 32'h0F24, 32'h1, 0,      1, "unmapped_wr");
    add(0, 32'h1F00, 0, 32'hDEADBEEF, 1, "unmapped_hi");
    add(1, A_ISET, 32'h0010, 0,     0, "iset_edge");
    add(0, A_RIS,  0, 32'h0010,     0, "ris_iset_edge");
    add(1, A_MODE, 32'h0001, 0,     0, "mode_wr");
    add(0, A_MODE, 0, 32'h0001,     0, "mode_rd");
    add(0, A_RIS,  0, 32'h0,        0, "ris_mode_chg");
    add(1, A_COAL, 32'h1FF, 0,      0, "coal_wr");
    add(0, A_COAL, 0, 32'hFF,       0, "coal_rd");
    add(1, A_TMO,  32'h12345, 0,    0, "tmo_wr");
    add(0, A_TMO,  0, 32'h2345,     0, "tmo_rd");
    add(1, A_IM,   32'h0, 0,        0, "im_clr");
    add(1, A_COAL, 32'h0, 0,        0, "coal_clr");
    add(1, A_TMO,  32'h0, 0,        0, "tmo_clr");

    repeat (3) @(posedge PCLK);
    @(negedge PCLK); PRESETn = 1'b1;
    tick(1);
    chk("irq_rst", {31'b0, IRQ}, 32'h0);
    chk("pready", {31'b0, PREADY}, 32'h1);

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        apb_wr(vecs[i].addr, vecs[i].data, e);
        chk({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].err});
      end else begin
        apb_rd(vecs[i].addr, d, e);
        chk(vecs[i].name, d, vecs[i].exp);
        chk({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].err});
      end
    end
    tick(2);

    // Edge source 0: RIS after 3 edges, IRQ one edge later, ICR clears.
    wr(A_MODE, 32'h1); wr(A_IM, 32'h1);
    @(negedge PCLK); irq_src[0] = 1'b1;
    tick(1); peek(A_RIS, d); chk("edge_ris_p1", d, 32'h0);
    @(negedge PCLK); irq_src[0] = 1'b0;
    tick(1); peek(A_RIS, d); chk("edge_ris_p2", d, 32'h0);
    tick(1); peek(A_RIS, d); chk("edge_ris_p3", d, 32'h1);
    chk("edge_irq_p3", {31'b0, IRQ}, 32'h0);
    tick(1); chk("edge_irq_p4", {31'b0, IRQ}, 32'h1);
    wr(A_ICR, 32'h1);
    peek(A_RIS, d); chk("edge_ris_icr", d, 32'h0);
    tick(1); chk("edge_irq_icr", {31'b0, IRQ}, 32'h0);

    // Level source 3, active-low.
    wr(A_IM, 32'h8);
    @(negedge PCLK); irq_src[3] = 1'b0;
    tick(3);
    peek(A_RIS, d); chk("lvl_ris_on", d, 32'h8);
    chk("lvl_irq_on", {31'b0, IRQ}, 32'h1);
    wr(A_ICR, 32'h8);
    peek(A_RIS, d); chk("lvl_ris_icr", d, 32'h8);
    chk("lvl_irq_icr", {31'b0, IRQ}, 32'h1);
    @(negedge PCLK); irq_src[3] = 1'b1;
    tick(2);
    peek(A_RIS, d); chk("lvl_ris_off", d, 32'h0);
    chk("lvl_irq_lag", {31'b0, IRQ}, 32'h1);
    tick(1); chk("lvl_irq_off", {31'b0, IRQ}, 32'h0);

    // Edge on source 1 and ICR of bit 1 on the same PCLK edge.
    wr(A_MODE, 32'h3); wr(A_IM, 32'h2);
    @(negedge PCLK); irq_src[1] = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_ICR; PWDATA = 32'h2;
    @(negedge PCLK); PENABLE = 1'b1;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    peek(A_RIS, d); chk("set_wins_ris1", d & 32'h2, 32'h2);
    wr(A_ICR, 32'h2);
    peek(A_RIS, d); chk("icr_ris1", d & 32'h2, 32'h0);
    @(negedge PCLK); irq_src[1] = 1'b0;
    tick(3);

    // Coalescing by count.
    wr(A_MODE, 32'hF); wr(A_IM, 32'hF); wr(A_COAL, 32'd4); wr(A_TMO, 32'd0);
    wr(A_ICR, 32'hF);
    pulse(16'h0001); chk("coal_irq_e1", {31'b0, IRQ}, 32'h0);
    pulse(16'h0006); chk("coal_irq_e2", {31'b0, IRQ}, 32'h0);
    peek(A_RIS, d);  chk("coal_ris", d, 32'h7);
    pulse(16'h0001); chk("coal_irq_e3", {31'b0, IRQ}, 32'h0);
    pulse(16'h0002); chk("coal_irq_e4", {31'b0, IRQ}, 32'h1);
    wr(A_ICR, 32'hF);
    peek(A_RIS, d); chk("coal_ris_icr", d, 32'h0);
    tick(1); chk("coal_irq_icr", {31'b0, IRQ}, 32'h0);
    pulse(16'h0001); chk("coal_cnt_cleared", {31'b0, IRQ}, 32'h0);
    wr(A_ICR, 32'hF);
    tick(2);

    // Coalescing by timeout.
    wr(A_COAL, 32'd10); wr(A_TMO, 32'd20);
    tmo_rise("tmo_first");
    wr(A_ICR, 32'h1);
    peek(A_RIS, d); chk("tmo_ris_icr", d, 32'h0);
    tick(1); chk("tmo_irq_icr", {31'b0, IRQ}, 32'h0);
    tmo_rise("tmo_second");
    wr(A_ICR, 32'h1);
    tick(2);

    // Asynchronous reset in the middle of a pending interrupt.
    wr(A_COAL, 32'd0);
    wr(A_ISET, 32'h1);
    tick(1); chk("pre_rst_irq", {31'b0, IRQ}, 32'h1);
    #2 PRESETn = 1'b0;
    #1 chk("async_rst_irq", {31'b0, IRQ}, 32'h0);
    peek(A_RIS, d);  chk("async_rst_ris", d, 32'h0);
    peek(A_MODE, d); chk("async_rst_mode", d, 32'h00F0);
    peek(A_IM, d);   chk("async_rst_im", d, 32'h0);
    @(negedge PCLK); PRESETn = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
